burst_producer: RTL and testbench
=================================

BURST_PRODUCER -- requirements
Module: burst_producer

Interface
REQ-001 The module SHALL expose three parameters, one per line as name, default, meaning:
  P_DATA_WIDTH, 8, data word width; legal values 8, 16, 32.
  P_MAX_BURST, 1024, maximum words per burst.
  P_IDLE_WIDTH, 4, width of the inter-word idle-count field.
REQ-002 The module SHALL expose these ports, one per line as name, direction, width, meaning:
  PROD_CLK  in  1  single clock; all logic on rising edge.
  RST_n  in  1  asynchronous active-low reset.
  START  in  1  one-cycle burst request; sampled only in IDLE.
  BURST_LEN  in  clog2(P_MAX_BURST+1)  words in burst; sampled with START.
  MODE  in  2  data mode (ZERO, ONES, RAND, INCR); sampled with START.
  WR_IDLE  in  P_IDLE_WIDTH  idle cycles inserted after each accepted word; sampled with START.
  SEED  in  P_DATA_WIDTH  LFSR seed (RAND) or start value (INCR); sampled with START.
  I_FULL  in  1  FIFO full flag.
  O_WR_EN  out  1  write strobe to FIFO.
  O_DATA  out  P_DATA_WIDTH  write data.
  BUSY  out  1  burst in progress.
  DONE  out  1  one-cycle pulse at burst end.
  WORD_CNT  out  clog2(P_MAX_BURST+1)  words accepted in current or last burst.
  CHECKSUM  out  P_DATA_WIDTH  XOR of all words accepted in current or last burst.

Function
REQ-003 A word SHALL be accepted on a PROD_CLK rising edge exactly when O_WR_EN=1 and I_FULL=0.
REQ-004 O_WR_EN SHALL equal (state==WRITE) AND NOT I_FULL, combinationally; O_DATA SHALL be registered and held stable until the word is accepted.
REQ-005 The FSM SHALL have the states IDLE, WRITE, GAP and DONE.
REQ-006 In IDLE, START=1 with BURST_LEN>0 SHALL capture all configuration inputs, clear WORD_CNT and CHECKSUM, load the first word, and enter WRITE on the next edge.
REQ-007 In IDLE, START=1 with BURST_LEN=0 SHALL go directly to DONE; START=1 with BURST_LEN>P_MAX_BURST SHALL be clamped to P_MAX_BURST.
REQ-008 In WRITE, on each accepted word, WORD_CNT SHALL increment, CHECKSUM SHALL XOR in O_DATA, and the next word SHALL be generated.
REQ-009 After an accepted word that is not the last, the FSM SHALL go to GAP when WR_IDLE>0, otherwise remain in WRITE, giving back-to-back words every cycle.
REQ-010 After the last accepted word (WORD_CNT reaches BURST_LEN), the FSM SHALL go to DONE.
REQ-011 In WRITE with I_FULL=1, the FSM SHALL hold: no state, data or count change.
REQ-012 GAP SHALL last exactly WR_IDLE cycles and then return to WRITE.
REQ-013 DONE SHALL last one cycle with DONE=1 and then return to IDLE.
REQ-014 BUSY SHALL be 1 in WRITE and GAP, and 0 in IDLE and DONE.
REQ-015 START SHALL be ignored outside IDLE.
REQ-016 Data modes SHALL be as follows:
  ZERO: every word is all-0.
  ONES: every word is all-1.
  INCR: first word is SEED, then +1 modulo 2^P_DATA_WIDTH.
  RAND: first word is SEED (SEED=0 replaced by 1), then maximal-length Galois LFSR next-state.
REQ-017 WORD_CNT and CHECKSUM SHALL hold their final values after DONE until the next START is accepted.

Reset
REQ-018 RST_n=0 SHALL asynchronously force state=IDLE, O_DATA=0, WORD_CNT=0, CHECKSUM=0, DONE=0 and BUSY=0, which makes O_WR_EN=0 immediately.
REQ-019 Reset mid-burst SHALL abandon the burst with no further writes; after release the block SHALL wait in IDLE for START.

Structure
REQ-020 Package ccd_pkg SHALL hold the MODE enum (ZERO=2'b00, ONES=2'b11, RAND=2'b01, INCR=2'b10), the FSM state enum, and the LFSR tap constants for 8 (0xB8), 16 (0xB400) and 32 (0x80200003).
REQ-021 The LFSR/counter next-word logic SHALL be a sub-module, lfsr_gen (inputs: mode, current word; output: next word).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  START, LEN=4, INCR, SEED=8'h10, WR_IDLE=0, I_FULL=0 -> O_WR_EN high 4 consecutive cycles; data 10,11,12,13; CHECKSUM=8'h00; DONE pulse; WORD_CNT=4.
  LEN=3, ONES, WR_IDLE=2 -> words spaced exactly 3 cycles apart; CHECKSUM=8'hFF.
  LEN=5, RAND, SEED=0 -> first word 8'h01, then the Galois 0xB8 sequence; 5 writes; checksum matches the model.
  LEN=4, INCR, I_FULL held 1 for 6 cycles mid-burst -> O_WR_EN=0 and O_DATA stable during stall; no lost or duplicated word.
  LEN=0, then LEN=2000 -> DONE on the cycle after START with no writes; then 1024 writes.
  RST_n pulsed low after word 2 of LEN=10 -> O_WR_EN=0 immediately, WORD_CNT=0, IDLE; a new burst then runs normally.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared types and constants for the burst producer.
// Holds the data-mode and FSM encodings plus LFSR tap masks.
package ccd_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RAND = 2'b01,
        INCR = 2'b10,
        ONES = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_GAP   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Galois feedback mask for a given word width
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            16:      return 32'(LFSR_TAPS_16);
            32:      return LFSR_TAPS_32;
            default: return 32'(LFSR_TAPS_8);
        endcase
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Next-word generator for the burst producer.
// Produces the word that follows i_word in the selected mode.
module lfsr_gen
    import ccd_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8
) (
    input  mode_e                   i_mode,
    input  logic [P_DATA_WIDTH-1:0] i_word,
    output logic [P_DATA_WIDTH-1:0] o_next
);

    localparam logic [P_DATA_WIDTH-1:0] L_TAPS =
        P_DATA_WIDTH'(lfsr_taps(P_DATA_WIDTH));

    logic [P_DATA_WIDTH-1:0] w_shift;

    assign w_shift = i_word >> 1;

    // Select successor word by mode (right-shift Galois LFSR for RAND)
    always_comb begin
        o_next = '0;
        unique case (i_mode)
            ZERO: o_next = '0;
            ONES: o_next = '1;
            INCR: o_next = i_word + P_DATA_WIDTH'(1);
            RAND: o_next = i_word[0] ? (w_shift ^ L_TAPS) : w_shift;
            default: o_next = '0;
        endcase
    end

endmodule

// File: rtl/burst_producer.sv
// Burst producer: writes a configurable burst of words into a FIFO,
// with optional idle gaps, full-flag back-pressure and a running XOR.
module burst_producer
    import ccd_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_MAX_BURST  = 1024,
    parameter int P_IDLE_WIDTH = 4
) (
    input  logic                               PROD_CLK,
    input  logic                               RST_n,
    input  logic                               START,
    input  logic [$clog2(P_MAX_BURST+1)-1:0]   BURST_LEN,
    input  logic [1:0]                         MODE,
    input  logic [P_IDLE_WIDTH-1:0]            WR_IDLE,
    input  logic [P_DATA_WIDTH-1:0]            SEED,
    input  logic                               I_FULL,
    output logic                               O_WR_EN,
    output logic [P_DATA_WIDTH-1:0]            O_DATA,
    output logic                               BUSY,
    output logic                               DONE,
    output logic [$clog2(P_MAX_BURST+1)-1:0]   WORD_CNT,
    output logic [P_DATA_WIDTH-1:0]            CHECKSUM
);

    localparam int L_CW = $clog2(P_MAX_BURST + 1);
    localparam logic [L_CW-1:0] L_MAX = L_CW'(P_MAX_BURST);

    state_e                  r_state;
    state_e                  w_next_state;
    mode_e                   r_mode;
    mode_e                   w_mode_in;
    logic [L_CW-1:0]         r_len;
    logic [L_CW-1:0]         r_cnt;
    logic [L_CW-1:0]         w_len_clamped;
    logic [P_IDLE_WIDTH-1:0] r_idle;
    logic [P_IDLE_WIDTH-1:0] r_gap;
    logic [P_DATA_WIDTH-1:0] r_data;
    logic [P_DATA_WIDTH-1:0] r_csum;
    logic [P_DATA_WIDTH-1:0] w_first;
    logic [P_DATA_WIDTH-1:0] w_next_word;
    logic                    w_start;
    logic                    w_accept;
    logic                    w_last;

    assign w_mode_in     = mode_e'(MODE);
    assign w_start       = (r_state == S_IDLE) && START;
    assign w_accept      = O_WR_EN;
    assign w_last        = (r_cnt + L_CW'(1)) == r_len;
    assign w_len_clamped = (BURST_LEN > L_MAX) ? L_MAX : BURST_LEN;

    assign O_WR_EN  = (r_state == S_WRITE) && !I_FULL;
    assign BUSY     = (r_state == S_WRITE) || (r_state == S_GAP);
    assign DONE     = (r_state == S_DONE);
    assign O_DATA   = r_data;
    assign WORD_CNT = r_cnt;
    assign CHECKSUM = r_csum;

    lfsr_gen #(
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_lfsr_gen (
        .i_mode (r_mode),
        .i_word (r_data),
        .o_next (w_next_word)
    );

    // First word of a burst; an all-zero LFSR seed would lock up, so use 1
    always_comb begin
        w_first = '0;
        unique case (w_mode_in)
            ZERO: w_first = '0;
            ONES: w_first = '1;
            INCR: w_first = SEED;
            RAND: w_first = (SEED == '0) ? P_DATA_WIDTH'(1) : SEED;
            default: w_first = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge PROD_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: stall on full, optional gap, one-cycle DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next_state = (BURST_LEN == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end else if (r_idle != '0) begin
                        w_next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap <= P_IDLE_WIDTH'(1)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Configuration capture, word generation, count and checksum
    always_ff @(posedge PROD_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_mode <= ZERO;
            r_len  <= '0;
            r_idle <= '0;
            r_gap  <= '0;
            r_cnt  <= '0;
            r_csum <= '0;
            r_data <= '0;
        end else if (w_start) begin
            r_mode <= w_mode_in;
            r_len  <= w_len_clamped;
            r_idle <= WR_IDLE;
            r_cnt  <= '0;
            r_csum <= '0;
            r_data <= w_first;
        end else if (w_accept) begin
            r_cnt  <= r_cnt + L_CW'(1);
            r_csum <= r_csum ^ r_data;
            r_data <= w_next_word;
            r_gap  <= r_idle;
        end else if (r_state == S_GAP) begin
            r_gap  <= r_gap - P_IDLE_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_burst_producer.sv
// Self-checking bench for burst_producer: directed scenarios plus
// randomized bursts checked against a word-list reference model.
module tb_burst_producer;

    localparam int DW   = 8;
    localparam int MAXB = 1024;
    localparam int IW   = 4;
    localparam int CW   = $clog2(MAXB + 1);

    localparam logic [1:0] M_ZERO = 2'b00;
    localparam logic [1:0] M_RAND = 2'b01;
    localparam logic [1:0] M_INCR = 2'b10;
    localparam logic [1:0] M_ONES = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] blen = '0;
    logic [1:0]    mode = 2'b00;
    logic [IW-1:0] wr_idle = '0;
    logic [DW-1:0] seed = '0;
    logic          full = 1'b0;
    logic          O_WR_EN;
    logic [DW-1:0] O_DATA;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] WORD_CNT;
    logic [DW-1:0] CHECKSUM;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] obs_w[$];
    int            obs_c[$];
    int            obs_done;
    bit            obs_full_wr;
    bit            obs_unstable;
    bit            obs_timeout;
    logic          obs_after_done;
    logic          obs_after_busy;
    logic [CW-1:0] obs_after_cnt;
    logic [DW-1:0] obs_after_sum;

    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] exp_sum;

    burst_producer #(
        .P_DATA_WIDTH (DW),
        .P_MAX_BURST  (MAXB),
        .P_IDLE_WIDTH (IW)
    ) dut (
        .PROD_CLK  (clk),
        .RST_n     (rst_n),
        .START     (start),
        .BURST_LEN (blen),
        .MODE      (mode),
        .WR_IDLE   (wr_idle),
        .SEED      (seed),
        .I_FULL    (full),
        .O_WR_EN   (O_WR_EN),
        .O_DATA    (O_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .WORD_CNT  (WORD_CNT),
        .CHECKSUM  (CHECKSUM)
    );

    always #5 clk = ~clk;

    // Reference: list of words a burst must deliver, and their XOR
    task automatic build_model(input int len, input logic [1:0] m,
                               input logic [DW-1:0] s);
        int n;
        logic [DW-1:0] v;
        logic [DW-1:0] w;
        n = (len > MAXB) ? MAXB : len;
        exp_w.delete();
        exp_sum = '0;
        v = (m == M_RAND && s == 0) ? 8'd1 : s;
        for (int k = 0; k < n; k++) begin
            if (m == M_ZERO) w = 8'h00;
            else if (m == M_ONES) w = 8'hFF;
            else w = v;
            exp_w.push_back(w);
            exp_sum = exp_sum ^ w;
            if (m == M_INCR) v = v + 8'd1;
            else if ((v & 8'd1) != 0) v = (v >> 1) ^ 8'hB8;
            else v = v >> 1;
        end
    endtask

    // Drive one burst and record every accepted word and its cycle
    task automatic run_burst(input int len, input logic [1:0] m,
                             input logic [DW-1:0] s, input int idle,
                             input int stall, input int budget);
        int cyc;
        int stall_left;
        bit prev_busy;
        bit prev_acc;
        logic [DW-1:0] prev_data;
        obs_w.delete();
        obs_c.delete();
        obs_done = -1;
        obs_full_wr = 0;
        obs_unstable = 0;
        obs_timeout = 0;
        @(negedge clk);
        start = 1'b1;
        blen = CW'(len);
        mode = m;
        wr_idle = IW'(idle);
        seed = s;
        full = 1'b0;
        @(negedge clk);
        start = 1'b0;
        blen = CW'($urandom);
        mode = 2'($urandom);
        wr_idle = IW'($urandom);
        seed = DW'($urandom);
        cyc = 1;
        stall_left = 6;
        prev_busy = 0;
        prev_acc = 0;
        prev_data = '0;
        forever begin
            if (stall == 1) begin
                full = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 4) == 0);
                blen = CW'($urandom);
            end else if (stall == 2) begin
                full = (obs_w.size() == 2 && stall_left > 0);
                if (full) stall_left--;
            end
            #1;
            if (DONE) begin
                obs_done = cyc;
                start = 1'b0;
                break;
            end
            if (O_WR_EN && full) obs_full_wr = 1;
            if (prev_busy && !prev_acc && BUSY && O_DATA !== prev_data)
                obs_unstable = 1;
            if (O_WR_EN) begin
                obs_w.push_back(O_DATA);
                obs_c.push_back(cyc);
            end
            prev_busy = BUSY;
            prev_acc = O_WR_EN;
            prev_data = O_DATA;
            cyc++;
            if (cyc > budget) begin
                obs_timeout = 1;
                start = 1'b0;
                break;
            end
            @(negedge clk);
        end
        full = 1'b0;
        obs_after_done = 1'b1;
        obs_after_busy = 1'b1;
        obs_after_cnt = '1;
        obs_after_sum = '1;
        if (!obs_timeout) begin
            @(negedge clk);
            #1;
            obs_after_done = DONE;
            obs_after_busy = BUSY;
            obs_after_cnt = WORD_CNT;
            obs_after_sum = CHECKSUM;
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if ({O_WR_EN, BUSY, DONE} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {O_WR_EN, BUSY, DONE});
        else n_pass++;
        n_total++;
        if (WORD_CNT !== '0 || CHECKSUM !== '0 || O_DATA !== '0)
            $display("FAIL reset_regs: cnt=%0d sum=%h data=%h want 0/00/00",
                     WORD_CNT, CHECKSUM, O_DATA);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (BUSY !== 1'b0 || O_WR_EN !== 1'b0)
            $display("FAIL reset_idle: busy=%b wr=%b want 0 0", BUSY, O_WR_EN);
        else n_pass++;
    endtask

    task automatic test_incr_back_to_back();
        int bad;
        build_model(4, M_INCR, 8'h10);
        run_burst(4, M_INCR, 8'h10, 0, 0, 50);
        n_total++;
        if (obs_w.size() != 4 || obs_timeout)
            $display("FAIL incr_writes: got %0d want 4", obs_w.size());
        else n_pass++;
        bad = 0;
        for (int k = 0; k < obs_w.size(); k++) begin
            if (k >= 4 || obs_w[k] !== 8'(8'h10 + k)) bad++;
            else if (obs_c[k] != k + 1) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL incr_data_timing: %0d bad words want 0", bad);
        else n_pass++;
        n_total++;
        if (obs_done != 5)
            $display("FAIL incr_done_cycle: got %0d want 5", obs_done);
        else n_pass++;
        n_total++;
        if (obs_after_cnt !== CW'(4) || obs_after_sum !== 8'h00)
            $display("FAIL incr_cnt_sum: cnt=%0d sum=%h want 4 00",
                     obs_after_cnt, obs_after_sum);
        else n_pass++;
        n_total++;
        if (obs_after_done !== 1'b0 || obs_after_busy !== 1'b0)
            $display("FAIL incr_done_pulse: done=%b busy=%b want 0 0",
                     obs_after_done, obs_after_busy);
        else n_pass++;
    endtask

    task automatic test_gap();
        int bad;
        run_burst(3, M_ONES, DW'($urandom), 2, 0, 50);
        n_total++;
        if (obs_w.size() != 3 || obs_timeout)
            $display("FAIL gap_writes: got %0d want 3", obs_w.size());
        else n_pass++;
        bad = 0;
        for (int k = 0; k < obs_w.size(); k++) begin
            if (obs_w[k] !== 8'hFF) bad++;
            if (k > 0 && obs_c[k] - obs_c[k-1] != 3) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL gap_spacing: %0d bad words want 0", bad);
        else n_pass++;
        n_total++;
        if (obs_after_sum !== 8'hFF || obs_after_cnt !== CW'(3))
            $display("FAIL gap_sum: sum=%h cnt=%0d want FF 3",
                     obs_after_sum, obs_after_cnt);
        else n_pass++;
    endtask

    task automatic test_rand_seed0();
        int bad;
        build_model(5, M_RAND, 8'h00);
        run_burst(5, M_RAND, 8'h00, 0, 0, 50);
        n_total++;
        if (obs_w.size() != 5 || obs_timeout)
            $display("FAIL rand_writes: got %0d want 5", obs_w.size());
        else n_pass++;
        n_total++;
        if (obs_w.size() == 0 || obs_w[0] !== 8'h01)
            $display("FAIL rand_first: got %h want 01",
                     (obs_w.size() == 0) ? 8'hxx : obs_w[0]);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < obs_w.size(); k++)
            if (k >= exp_w.size() || obs_w[k] !== exp_w[k]) bad++;
        n_total++;
        if (bad != 0)
            $display("FAIL rand_seq: %0d bad words want 0", bad);
        else n_pass++;
        n_total++;
        if (obs_after_sum !== exp_sum || obs_after_sum !== 8'hDC)
            $display("FAIL rand_sum: got %h want %h", obs_after_sum, exp_sum);
        else n_pass++;
    endtask

    task automatic test_stall();
        int bad;
        run_burst(4, M_INCR, 8'h20, 0, 2, 50);
        bad = 0;
        for (int k = 0; k < obs_w.size(); k++)
            if (obs_w[k] !== 8'(8'h20 + k)) bad++;
        n_total++;
        if (obs_w.size() != 4 || bad != 0 || obs_timeout)
            $display("FAIL stall_words: n=%0d bad=%0d want 4 0",
                     obs_w.size(), bad);
        else n_pass++;
        n_total++;
        if (obs_full_wr || obs_unstable)
            $display("FAIL stall_hold: wr_when_full=%0d unstable=%0d want 0 0",
                     obs_full_wr, obs_unstable);
        else n_pass++;
        n_total++;
        if (obs_c.size() < 3 || obs_c[2] != 9)
            $display("FAIL stall_resume: got cycle %0d want 9",
                     (obs_c.size() < 3) ? -1 : obs_c[2]);
        else n_pass++;
        n_total++;
        if (obs_after_cnt !== CW'(4))
            $display("FAIL stall_cnt: got %0d want 4", obs_after_cnt);
        else n_pass++;
    endtask

    task automatic test_len_limits();
        int bad;
        run_burst(0, M_INCR, 8'h55, 0, 0, 20);
        n_total++;
        if (obs_done != 1 || obs_w.size() != 0)
            $display("FAIL len0: done_cycle=%0d writes=%0d want 1 0",
                     obs_done, obs_w.size());
        else n_pass++;
        n_total++;
        if (obs_after_cnt !== '0)
            $display("FAIL len0_cnt: got %0d want 0", obs_after_cnt);
        else n_pass++;
        build_model(2000, M_INCR, 8'hF0);
        run_burst(2000, M_INCR, 8'hF0, 0, 0, 3000);
        n_total++;
        if (obs_w.size() != MAXB || obs_done != MAXB + 1)
            $display("FAIL len_clamp: writes=%0d done=%0d want 1024 1025",
                     obs_w.size(), obs_done);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < obs_w.size(); k++)
            if (k >= exp_w.size() || obs_w[k] !== exp_w[k]) bad++;
        n_total++;
        if (bad != 0 || obs_after_cnt !== CW'(MAXB) || obs_after_sum !== exp_sum)
            $display("FAIL len_clamp_data: bad=%0d cnt=%0d sum=%h want 0 1024 %h",
                     bad, obs_after_cnt, obs_after_sum, exp_sum);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit leak;
        int bad;
        @(negedge clk);
        start = 1'b1;
        blen = CW'(10);
        mode = M_INCR;
        wr_idle = '0;
        seed = 8'h30;
        full = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (WORD_CNT !== CW'(2) || O_WR_EN !== 1'b1)
            $display("FAIL rst_pre: cnt=%0d wr=%b want 2 1", WORD_CNT, O_WR_EN);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (O_WR_EN !== 1'b0 || WORD_CNT !== '0 || BUSY !== 1'b0)
            $display("FAIL rst_async: wr=%b cnt=%0d busy=%b want 0 0 0",
                     O_WR_EN, WORD_CNT, BUSY);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        leak = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (O_WR_EN || BUSY) leak = 1;
        end
        n_total++;
        if (leak)
            $display("FAIL rst_idle_wait: activity=%0d want 0", leak);
        else n_pass++;
        run_burst(3, M_INCR, 8'h30, 0, 0, 50);
        bad = 0;
        for (int k = 0; k < obs_w.size(); k++)
            if (obs_w[k] !== 8'(8'h30 + k)) bad++;
        n_total++;
        if (obs_w.size() != 3 || bad != 0 || obs_after_cnt !== CW'(3))
            $display("FAIL rst_recover: n=%0d bad=%0d cnt=%0d want 3 0 3",
                     obs_w.size(), bad, obs_after_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int len;
        int idle;
        int bad;
        logic [1:0] m;
        logic [DW-1:0] s;
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 24);
            idle = $urandom_range(0, 3);
            m = 2'($urandom);
            s = DW'($urandom);
            if (it % 5 == 0) s = '0;
            build_model(len, m, s);
            run_burst(len, m, s, idle, 1, 400);
            bad = 0;
            for (int k = 0; k < obs_w.size(); k++)
                if (k >= exp_w.size() || obs_w[k] !== exp_w[k]) bad++;
            n_total++;
            if (obs_w.size() != exp_w.size() || bad != 0 || obs_timeout)
                $display("FAIL rand_%0d_words: n=%0d bad=%0d want %0d 0",
                         it, obs_w.size(), bad, exp_w.size());
            else n_pass++;
            n_total++;
            if (obs_after_cnt !== CW'(len) || obs_after_sum !== exp_sum)
                $display("FAIL rand_%0d_cnt_sum: cnt=%0d sum=%h want %0d %h",
                         it, obs_after_cnt, obs_after_sum, len, exp_sum);
            else n_pass++;
            n_total++;
            if (obs_full_wr || obs_unstable || obs_after_done !== 1'b0)
                $display("FAIL rand_%0d_proto: fullwr=%0d unstable=%0d done=%b want 0 0 0",
                         it, obs_full_wr, obs_unstable, obs_after_done);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_incr_back_to_back();
        test_gap();
        test_rand_seed0();
        test_stall();
        test_len_limits();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
